// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the fetch stage: instruction width, bubble encoding and fetch FSM states.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR_VAL = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: async reset to a bubble, hold freezes contents, flush loads a bubble.
module if_id_pipe_reg
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_VAL
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic            if_valid
);

  // flush wins over hold: a redirect from EX must squash even a stalled slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_pc       <= '0;
      if_instr    <= NOP_INSTR;
      if_pc_plus4 <= '0;
      if_valid    <= 1'b0;
    end else if (flush) begin
      if_pc       <= pc_in;
      if_instr    <= NOP_INSTR;
      if_pc_plus4 <= pc_in + 32'd4;
      if_valid    <= 1'b0;
    end else if (!hold) begin
      if_pc       <= pc_in;
      if_instr    <= instr_in;
      if_pc_plus4 <= pc_in + 32'd4;
      if_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// RV32IM fetch stage: PC, wait-state IMEM handshake, stalls and EX redirects (incl. in-flight squash).
// Optional perf counters enabled by defining IF_PERF_CNT_EN.
module if_fetch_stage
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_VAL
`ifdef IF_PERF_CNT_EN
  ,
  parameter int          PERF_CNT_W = 32
`endif
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_READ,
  input  logic [31:0] IMEM_RDATA,
  input  logic        IMEM_BUSY,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_INSTRUCTION,
  output logic [31:0] IF_PC_PLUS4,
  output logic        IF_VALID,
`ifdef IF_PERF_CNT_EN
  output logic [PERF_CNT_W-1:0] FETCH_CNT,
  output logic [PERF_CNT_W-1:0] STALL_CNT,
  output logic [PERF_CNT_W-1:0] BUBBLE_CNT,
`endif
  output logic [1:0]  DBG_STATE
);

  // IMEM handshake: IMEM_READ is held high whenever out of reset; an access
  // completes in any cycle with IMEM_BUSY=0, and IMEM_RDATA is valid only then.

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redir_q, redir_d;
  logic [31:0]  target;
  logic         complete;
  logic         ifid_hold;
  logic         ifid_flush;

  assign target   = word_align(BRANCH_TARGET);
  assign complete = !IMEM_BUSY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_FETCH;
      pc_q    <= word_align(RESET_PC);
      redir_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_d    = redir_q;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    case (state_q)
      ST_DRAIN: begin
        // the in-flight word belongs to a squashed path; newest redirect wins
        ifid_flush = 1'b1;
        if (BRANCH_TAKEN) redir_d = target;
        if (complete) begin
          pc_d    = BRANCH_TAKEN ? target : redir_q;
          state_d = ST_FETCH;
        end
      end
      default: begin
        if (BRANCH_TAKEN) begin
          ifid_flush = 1'b1;
          if (complete) begin
            pc_d    = target;
            state_d = ST_FETCH;
          end else begin
            redir_d = target;
            state_d = ST_DRAIN;
          end
        end else if (STALL) begin
          // a completed word is dropped and simply re-read next cycle
          ifid_hold = 1'b1;
          state_d   = complete ? ST_FETCH : ST_WAIT;
        end else if (complete) begin
          pc_d    = pc_q + 32'd4;
          state_d = ST_FETCH;
        end else begin
          ifid_flush = 1'b1;
          state_d    = ST_WAIT;
        end
      end
    endcase
  end

  assign IMEM_ADDR = pc_q;
  assign IMEM_READ = !RST;
  assign DBG_STATE = state_q;

  if_id_pipe_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk         (CLK),
    .rst         (RST),
    .hold        (ifid_hold),
    .flush       (ifid_flush),
    .pc_in       (pc_q),
    .instr_in    (IMEM_RDATA),
    .if_pc       (IF_PC),
    .if_instr    (IF_INSTRUCTION),
    .if_pc_plus4 (IF_PC_PLUS4),
    .if_valid    (IF_VALID)
  );

`ifdef IF_PERF_CNT_EN
  logic fetch_evt;
  assign fetch_evt = !ifid_flush && !ifid_hold;

  // saturating: counters stick at all-ones rather than wrapping
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      FETCH_CNT  <= '0;
      STALL_CNT  <= '0;
      BUBBLE_CNT <= '0;
    end else begin
      if (fetch_evt && (FETCH_CNT != '1))
        FETCH_CNT <= FETCH_CNT + PERF_CNT_W'(1);
      if (STALL && (STALL_CNT != '1))
        STALL_CNT <= STALL_CNT + PERF_CNT_W'(1);
      if (ifid_flush && (BUBBLE_CNT != '1))
        BUBBLE_CNT <= BUBBLE_CNT + PERF_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then random traffic against a behavioural fetch model.
module tb_if_fetch_stage;
  import rv32_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST;
  logic        STALL;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READ;
  logic [31:0] IMEM_RDATA;
  logic        IMEM_BUSY;
  logic [31:0] IF_PC;
  logic [31:0] IF_INSTRUCTION;
  logic [31:0] IF_PC_PLUS4;
  logic        IF_VALID;
  logic [1:0]  DBG_STATE;
`ifdef IF_PERF_CNT_EN
  logic [31:0] FETCH_CNT, STALL_CNT, BUBBLE_CNT;
`endif

  int n_vec = 0;
  int n_err = 0;

  // reference model: architectural PC, pending squash, expected IF/ID contents
  logic [31:0] m_pc, m_redir;
  logic        m_squash;
  logic [31:0] m_if_pc, m_if_pc4, m_if_instr;
  logic        m_if_valid, m_pc_known;
  logic [31:0] exp_q[$];

  if_fetch_stage dut (
    .CLK            (CLK),
    .RST            (RST),
    .STALL          (STALL),
    .BRANCH_TAKEN   (BRANCH_TAKEN),
    .BRANCH_TARGET  (BRANCH_TARGET),
    .IMEM_ADDR      (IMEM_ADDR),
    .IMEM_READ      (IMEM_READ),
    .IMEM_RDATA     (IMEM_RDATA),
    .IMEM_BUSY      (IMEM_BUSY),
    .IF_PC          (IF_PC),
    .IF_INSTRUCTION (IF_INSTRUCTION),
    .IF_PC_PLUS4    (IF_PC_PLUS4),
    .IF_VALID       (IF_VALID),
`ifdef IF_PERF_CNT_EN
    .FETCH_CNT      (FETCH_CNT),
    .STALL_CNT      (STALL_CNT),
    .BUBBLE_CNT     (BUBBLE_CNT),
`endif
    .DBG_STATE      (DBG_STATE)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    STALL = 1'b0;
    BRANCH_TAKEN = 1'b0;
    BRANCH_TARGET = '0;
    IMEM_BUSY = 1'b0;
    IMEM_RDATA = '0;
    #2;
    chk("rst_imem_read", {31'b0, IMEM_READ}, 32'd0);
    chk("rst_if_valid", {31'b0, IF_VALID}, 32'd0);
    chk("rst_if_instr", IF_INSTRUCTION, NOP);
    chk("rst_if_pc", IF_PC, 32'd0);
    chk("rst_if_pc4", IF_PC_PLUS4, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    m_pc = 32'd0;
    m_redir = 32'd0;
    m_squash = 1'b0;
    m_if_pc = 32'd0;
    m_if_pc4 = 32'd0;
    m_if_instr = NOP;
    m_if_valid = 1'b0;
    m_pc_known = 1'b1;
    exp_q.delete();
  endtask

  // driver: apply one cycle of inputs, check the request, then the IF/ID result
  task automatic step(input logic stall, input logic br, input logic [31:0] tgt, input logic busy);
    logic [31:0] t;
    logic        m_new;
    STALL = stall;
    BRANCH_TAKEN = br;
    BRANCH_TARGET = tgt;
    IMEM_BUSY = busy;
    IMEM_RDATA = busy ? $urandom : tag_of(m_pc);
    #1;
    chk("imem_addr", IMEM_ADDR, m_pc);
    chk("imem_read", {31'b0, IMEM_READ}, 32'd1);
    @(posedge CLK);
    #1;
    t = tgt & ~32'd3;
    m_new = 1'b0;
    if (m_squash) begin
      if (br) m_redir = t;
      m_if_valid = 1'b0;
      m_if_instr = NOP;
      m_pc_known = 1'b0;
      if (!busy) begin
        m_pc = m_redir;
        m_squash = 1'b0;
      end
    end else if (br) begin
      m_if_valid = 1'b0;
      m_if_instr = NOP;
      m_pc_known = 1'b0;
      if (busy) begin
        m_squash = 1'b1;
        m_redir = t;
      end else begin
        m_pc = t;
      end
    end else if (!stall) begin
      m_if_pc = m_pc;
      m_if_pc4 = m_pc + 32'd4;
      m_pc_known = 1'b1;
      if (!busy) begin
        m_if_instr = tag_of(m_pc);
        m_if_valid = 1'b1;
        exp_q.push_back(tag_of(m_pc));
        m_new = 1'b1;
        m_pc = m_pc + 32'd4;
      end else begin
        m_if_instr = NOP;
        m_if_valid = 1'b0;
      end
    end
    chk("if_valid", {31'b0, IF_VALID}, {31'b0, m_if_valid});
    if (m_new) chk("if_instr_new", IF_INSTRUCTION, exp_q.pop_front());
    else       chk("if_instr", IF_INSTRUCTION, m_if_instr);
    if (m_pc_known) begin
      chk("if_pc", IF_PC, m_if_pc);
      chk("if_pc4", IF_PC_PLUS4, m_if_pc4);
    end
  endtask

  initial begin
    do_reset();
    // sequential fetch from reset
    repeat (4) step(1'b0, 1'b0, 32'd0, 1'b0);
    // three wait states at 0x10
    repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 32'd0, 1'b0);
    // stall with IF_PC=0x20
    repeat (2) step(1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    // redirect overrides stall, low bits ignored
    step(1'b1, 1'b1, 32'h0000_0103, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    // redirect during a busy access at 0x40
    step(1'b0, 1'b1, 32'h0000_0040, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    repeat (2) step(1'b0, 1'b0, 32'd0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 32'd0, 1'b0);
    // second redirect while draining: last one wins
    step(1'b0, 1'b1, 32'h0000_0300, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0406, 1'b1);
    repeat (2) step(1'b0, 1'b0, 32'd0, 1'b0);
    // PC wrap at the top of the address space
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    repeat (2) step(1'b0, 1'b0, 32'd0, 1'b0);
    // reset asserted while an access waits
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("state_wait", {30'b0, DBG_STATE}, {30'b0, ST_WAIT});
    do_reset();
    step(1'b0, 1'b0, 32'd0, 1'b0);
    // random traffic
    for (int i = 0; i < 800; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, tgt, $urandom_range(0, 3) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
